// File: rtl/axil_regfile_pkg.sv
// Shared types and helpers for the AXI4-Lite register file.
package axil_regfile_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {W_IDLE, W_RESP} wr_state_t;
  typedef enum logic {R_IDLE, R_DATA} rd_state_t;

  function automatic logic idx_in_range(input logic [63:0] idx, input int numRegs);
    return idx < 64'(numRegs);
  endfunction

  // Bytes per data word decide how many low address bits are dropped.
  function automatic int addr_lsb(input int dataWidth);
    return (dataWidth == 64) ? 3 : 2;
  endfunction

endpackage

// File: rtl/axil_regfile_if.sv
// AXI4-Lite bus bundle shared by the register file and its host master.
interface axil_regfile_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wvalid;
  logic                    wready;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic                    arvalid;
  logic                    arready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rvalid;
  logic                    rready;

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

endinterface

// File: rtl/axil_regfile_wr_ch.sv
// Write channel: independent AW/W capture and the B response FSM.
// Presents a one-cycle commit with the captured word index, data and strobes.
module axil_regfile_wr_ch
  import axil_regfile_pkg::*;
#(
  parameter  int ADDR_WIDTH = 32,
  parameter  int DATA_WIDTH = 32,
  parameter  int NUM_REGS   = 32,
  localparam int LSB        = addr_lsb(DATA_WIDTH),
  localparam int IDX_W      = ADDR_WIDTH - LSB
) (
  input  logic                    axi_aclk,
  input  logic                    axi_resetn,
  axil_regfile_if.slave           axi,
  output logic                    commit_o,
  output logic                    inRange_o,
  output logic [IDX_W-1:0]        idx_o,
  output logic [DATA_WIDTH-1:0]   data_o,
  output logic [DATA_WIDTH/8-1:0] strb_o
);

  wr_state_t               state_q, state_d;
  logic                    awHeld_q, awHeld_d;
  logic                    wHeld_q, wHeld_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic [DATA_WIDTH/8-1:0] strb_q, strb_d;
  logic [1:0]              bresp_q, bresp_d;
  logic                    unusedAwLow;

  always_ff @(posedge axi_aclk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      state_q  <= W_IDLE;
      awHeld_q <= 1'b0;
      wHeld_q  <= 1'b0;
      idx_q    <= '0;
      data_q   <= '0;
      strb_q   <= '0;
      bresp_q  <= RESP_OKAY;
    end else begin
      state_q  <= state_d;
      awHeld_q <= awHeld_d;
      wHeld_q  <= wHeld_d;
      idx_q    <= idx_d;
      data_q   <= data_d;
      strb_q   <= strb_d;
      bresp_q  <= bresp_d;
    end
  end

  // Each channel latches on its own handshake; commit waits until both are held.
  always_comb begin
    state_d  = state_q;
    awHeld_d = awHeld_q;
    wHeld_d  = wHeld_q;
    idx_d    = idx_q;
    data_d   = data_q;
    strb_d   = strb_q;
    bresp_d  = bresp_q;
    commit_o = 1'b0;
    case (state_q)
      W_IDLE: begin
        if (axi.awvalid && !awHeld_q) begin
          awHeld_d = 1'b1;
          idx_d    = axi.awaddr[ADDR_WIDTH-1:LSB];
        end
        if (axi.wvalid && !wHeld_q) begin
          wHeld_d = 1'b1;
          data_d  = axi.wdata;
          strb_d  = axi.wstrb;
        end
        if (awHeld_q && wHeld_q) begin
          commit_o = 1'b1;
          bresp_d  = idx_in_range(64'(idx_q), NUM_REGS) ? RESP_OKAY : RESP_SLVERR;
          state_d  = W_RESP;
        end
      end
      W_RESP: begin
        if (axi.bready) begin
          state_d  = W_IDLE;
          awHeld_d = 1'b0;
          wHeld_d  = 1'b0;
        end
      end
      default: state_d = W_IDLE;
    endcase
  end

  assign axi.awready = (state_q == W_IDLE) && !awHeld_q;
  assign axi.wready  = (state_q == W_IDLE) && !wHeld_q;
  assign axi.bvalid  = (state_q == W_RESP);
  assign axi.bresp   = bresp_q;

  assign inRange_o   = idx_in_range(64'(idx_q), NUM_REGS);
  assign idx_o       = idx_q;
  assign data_o      = data_q;
  assign strb_o      = strb_q;
  assign unusedAwLow = ^axi.awaddr[LSB-1:0];

endmodule

// File: rtl/axil_regfile.sv
// AXI4-Lite control/status register file with RO status mapping and write/read strobes.
// Define AXIL_REGFILE_PULSE_EN to make PULSE_MASK registers self-clear after one cycle.
module axil_regfile
  import axil_regfile_pkg::*;
#(
  parameter  int                             ADDR_WIDTH = 32,
  parameter  int                             DATA_WIDTH = 32,
  parameter  int                             NUM_REGS   = 32,
  parameter  logic [NUM_REGS-1:0]            RO_MASK    = '0,
  parameter  logic [NUM_REGS*DATA_WIDTH-1:0] RST_VAL    = '0,
  parameter  logic [NUM_REGS-1:0]            PULSE_MASK = '0,
  localparam int                             LSB        = addr_lsb(DATA_WIDTH),
  localparam int                             IDX_W      = ADDR_WIDTH - LSB
) (
  input  logic                           axi_aclk,
  input  logic                           axi_resetn,
  axil_regfile_if.slave                  axi,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] reg_in,
  output logic [NUM_REGS-1:0]            wr_stb,
  output logic [NUM_REGS-1:0]            rd_stb
);

`ifdef AXIL_REGFILE_PULSE_EN
  localparam logic [NUM_REGS-1:0] PULSE_ACTIVE = PULSE_MASK;
`else
  localparam logic [NUM_REGS-1:0] PULSE_ACTIVE = '0;
  localparam logic [NUM_REGS-1:0] unusedPulseMask = PULSE_MASK;
`endif

  logic                    wrCommit, wrInRange;
  logic [IDX_W-1:0]        wrIdx;
  logic [DATA_WIDTH-1:0]   wrData;
  logic [DATA_WIDTH/8-1:0] wrStrb;
  logic [NUM_REGS-1:0]     wrHit, rdHit;
  logic [NUM_REGS-1:0]     wrStb_q, rdStb_q;
  logic [DATA_WIDTH-1:0]   regs_q [NUM_REGS];
  rd_state_t               rdState_q, rdState_d;
  logic [DATA_WIDTH-1:0]   rdData_q, rdData_d;
  logic [1:0]              rdResp_q, rdResp_d;
  logic [IDX_W-1:0]        arIdx;
  logic                    unusedArLow;

  axil_regfile_wr_ch #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_REGS   (NUM_REGS)
  ) u_wr_ch (
    .axi_aclk   (axi_aclk),
    .axi_resetn (axi_resetn),
    .axi        (axi),
    .commit_o   (wrCommit),
    .inRange_o  (wrInRange),
    .idx_o      (wrIdx),
    .data_o     (wrData),
    .strb_o     (wrStrb)
  );

  // Read-only registers silently absorb writes: OKAY response but no update or strobe.
  always_comb begin
    wrHit = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      wrHit[i] = wrCommit && wrInRange && (wrIdx == IDX_W'(i)) && !RO_MASK[i];
    end
  end

  always_ff @(posedge axi_aclk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= RST_VAL[i*DATA_WIDTH +: DATA_WIDTH];
      end
      wrStb_q <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (PULSE_ACTIVE[i]) begin
          regs_q[i] <= RST_VAL[i*DATA_WIDTH +: DATA_WIDTH];
        end
        if (wrHit[i]) begin
          for (int b = 0; b < DATA_WIDTH/8; b++) begin
            if (wrStrb[b]) begin
              regs_q[i][b*8 +: 8] <= wrData[b*8 +: 8];
            end
          end
        end
      end
      wrStb_q <= wrHit;
    end
  end

  assign arIdx       = axi.araddr[ADDR_WIDTH-1:LSB];
  assign unusedArLow = ^axi.araddr[LSB-1:0];

  always_ff @(posedge axi_aclk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      rdState_q <= R_IDLE;
      rdData_q  <= '0;
      rdResp_q  <= RESP_OKAY;
      rdStb_q   <= '0;
    end else begin
      rdState_q <= rdState_d;
      rdData_q  <= rdData_d;
      rdResp_q  <= rdResp_d;
      rdStb_q   <= rdHit;
    end
  end

  // The read samples the array before any same-cycle write lands, so it sees the old value.
  always_comb begin
    rdState_d = rdState_q;
    rdData_d  = rdData_q;
    rdResp_d  = rdResp_q;
    rdHit     = '0;
    case (rdState_q)
      R_IDLE: begin
        if (axi.arvalid) begin
          rdState_d = R_DATA;
          rdResp_d  = idx_in_range(64'(arIdx), NUM_REGS) ? RESP_OKAY : RESP_SLVERR;
          rdData_d  = '0;
          for (int i = 0; i < NUM_REGS; i++) begin
            if (arIdx == IDX_W'(i)) begin
              rdHit[i] = 1'b1;
              if (RO_MASK[i]) begin
                rdData_d = reg_in[i*DATA_WIDTH +: DATA_WIDTH];
              end else if (PULSE_ACTIVE[i]) begin
                rdData_d = RST_VAL[i*DATA_WIDTH +: DATA_WIDTH];
              end else begin
                rdData_d = regs_q[i];
              end
            end
          end
        end
      end
      R_DATA: begin
        if (axi.rready) begin
          rdState_d = R_IDLE;
        end
      end
      default: rdState_d = R_IDLE;
    endcase
  end

  assign axi.arready = (rdState_q == R_IDLE);
  assign axi.rvalid  = (rdState_q == R_DATA);
  assign axi.rdata   = rdData_q;
  assign axi.rresp   = rdResp_q;

  always_comb begin
    reg_out = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      reg_out[i*DATA_WIDTH +: DATA_WIDTH] = regs_q[i];
    end
  end

  assign wr_stb = wrStb_q;
  assign rd_stb = rdStb_q;

endmodule

// File: tb/tb_axil_regfile.sv
// Self-checking bench for axil_regfile: directed scenarios plus random traffic against a register model.
module tb_axil_regfile;
  import axil_regfile_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int NR = 8;
  localparam logic [NR-1:0]    RO_MASK    = 8'b0000_0010;
  localparam logic [NR-1:0]    PULSE_MASK = 8'b0000_0001;
  localparam logic [NR*DW-1:0] RST_VAL    = {32'hCAFE_0000, 32'h0000_0000, 32'h0000_0000, 32'h1234_5678,
                                             32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000};

  typedef logic [NR*DW-1:0] vec_t;

  logic axi_aclk   = 1'b0;
  logic axi_resetn = 1'b0;
  vec_t reg_out, reg_in;
  logic [NR-1:0] wr_stb, rd_stb;

  axil_regfile_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) axi ();

  axil_regfile #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .NUM_REGS   (NR),
    .RO_MASK    (RO_MASK),
    .RST_VAL    (RST_VAL),
    .PULSE_MASK (PULSE_MASK)
  ) dut (
    .axi_aclk   (axi_aclk),
    .axi_resetn (axi_resetn),
    .axi        (axi),
    .reg_out    (reg_out),
    .reg_in     (reg_in),
    .wr_stb     (wr_stb),
    .rd_stb     (rd_stb)
  );

  always #5 axi_aclk = ~axi_aclk;

  int checks = 0;
  int fails  = 0;
  int wrStbCnt [NR] = '{default: 0};
  int rdStbCnt [NR] = '{default: 0};
  int pulseHighCycles = 0;
  logic [DW-1:0] model [NR];

  // Strobe counters accumulate every cycle a strobe bit is high.
  always @(negedge axi_aclk) begin
    for (int i = 0; i < NR; i++) begin
      if (wr_stb[i]) wrStbCnt[i]++;
      if (rd_stb[i]) rdStbCnt[i]++;
    end
    if (reg_out[DW-1:0] == 32'h5A5A_0001) pulseHighCycles++;
  end

  task automatic checkOutput(input string tag, input vec_t observed, input vec_t expected);
    checks++;
    assert (observed === expected) else begin
      fails++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  function automatic logic [DW-1:0] expectedRead(input int idx);
    if (idx >= NR) return '0;
    if (RO_MASK[idx]) return reg_in[idx*DW +: DW];
`ifdef AXIL_REGFILE_PULSE_EN
    if (PULSE_MASK[idx]) return RST_VAL[idx*DW +: DW];
`endif
    return model[idx];
  endfunction

  function automatic logic [1:0] expectedResp(input int idx);
    return (idx < NR) ? RESP_OKAY : RESP_SLVERR;
  endfunction

  function automatic void modelWrite(input int idx, input logic [DW-1:0] data, input logic [DW/8-1:0] strb);
    if (idx >= NR || RO_MASK[idx]) return;
`ifdef AXIL_REGFILE_PULSE_EN
    if (PULSE_MASK[idx]) return;
`endif
    for (int b = 0; b < DW/8; b++) begin
      if (strb[b]) model[idx][b*8 +: 8] = data[b*8 +: 8];
    end
  endfunction

  // One complete AXI write; AW and W are offered after their own cycle delays.
  task automatic applyStimulus(input logic [AW-1:0] addr, input logic [DW-1:0] data,
                               input logic [DW/8-1:0] strb, input int awDelay, input int wDelay,
                               output logic [1:0] resp);
    logic awFire, wFire, awDone, wDone;
    awFire = 1'b0; wFire = 1'b0; awDone = 1'b0; wDone = 1'b0;
    for (int t = 0; t < 50 && !(awDone && wDone); t++) begin
      @(negedge axi_aclk);
      if (awFire) begin axi.awvalid = 1'b0; awDone = 1'b1; end
      if (wFire)  begin axi.wvalid  = 1'b0; wDone  = 1'b1; end
      if (!awDone && t >= awDelay) begin axi.awvalid = 1'b1; axi.awaddr = addr; end
      if (!wDone && t >= wDelay) begin axi.wvalid = 1'b1; axi.wdata = data; axi.wstrb = strb; end
      awFire = axi.awvalid && axi.awready;
      wFire  = axi.wvalid && axi.wready;
    end
    axi.awvalid = 1'b0;
    axi.wvalid  = 1'b0;
    checkOutput("aw_w_accepted", vec_t'({awDone, wDone}), vec_t'(2'b11));
    axi.bready = 1'b1;
    for (int t = 0; t < 20 && !axi.bvalid; t++) @(negedge axi_aclk);
    checkOutput("bvalid_seen", vec_t'(axi.bvalid), vec_t'(1'b1));
    resp = axi.bresp;
    @(negedge axi_aclk);
    axi.bready = 1'b0;
    checkOutput("aw_w_ready_after_b", vec_t'({axi.awready, axi.wready, axi.bvalid}), vec_t'(3'b110));
  endtask

  task automatic issueRead(input logic [AW-1:0] addr, output logic [DW-1:0] data, output logic [1:0] resp);
    logic arFire;
    @(negedge axi_aclk);
    axi.arvalid = 1'b1;
    axi.araddr  = addr;
    arFire = axi.arready;
    for (int t = 0; t < 20 && !arFire; t++) begin
      @(negedge axi_aclk);
      arFire = axi.arready;
    end
    @(negedge axi_aclk);
    axi.arvalid = 1'b0;
    checkOutput("ar_accepted", vec_t'(arFire), vec_t'(1'b1));
    axi.rready = 1'b1;
    for (int t = 0; t < 20 && !axi.rvalid; t++) @(negedge axi_aclk);
    checkOutput("rvalid_seen", vec_t'(axi.rvalid), vec_t'(1'b1));
    data = axi.rdata;
    resp = axi.rresp;
    @(negedge axi_aclk);
    axi.rready = 1'b0;
  endtask

  initial begin
    logic [1:0]    resp, rresp;
    logic [DW-1:0] rdata;
    vec_t          snapshot;
    int            cntBefore;

    axi.awvalid = 1'b0; axi.awaddr = '0;
    axi.wvalid  = 1'b0; axi.wdata  = '0; axi.wstrb = '0;
    axi.bready  = 1'b0;
    axi.arvalid = 1'b0; axi.araddr = '0;
    axi.rready  = 1'b0;
    for (int i = 0; i < NR; i++) begin
      reg_in[i*DW +: DW] = $urandom;
      model[i] = RST_VAL[i*DW +: DW];
    end
    reg_in[1*DW +: DW] = 32'hDEAD_BEEF;

    // Reset state, both while held and after release.
    repeat (3) @(negedge axi_aclk);
    checkOutput("rst_reg_out", reg_out, RST_VAL);
    checkOutput("rst_flags", vec_t'({axi.awready, axi.wready, axi.arready, axi.bvalid, axi.rvalid}), vec_t'(5'b11100));
    checkOutput("rst_resp_data", vec_t'({axi.bresp, axi.rresp, axi.rdata}), vec_t'(0));
    checkOutput("rst_strobes", vec_t'({wr_stb, rd_stb}), vec_t'(0));
    axi_resetn = 1'b1;
    @(negedge axi_aclk);
    checkOutput("post_rst_reg_out", reg_out, RST_VAL);
    checkOutput("post_rst_flags", vec_t'({axi.awready, axi.wready, axi.arready, axi.bvalid, axi.rvalid}), vec_t'(5'b11100));

    $display("[TB] W before AW with partial strobes");
    cntBefore = wrStbCnt[2];
    applyStimulus(32'h08, 32'hA5A5_A5A5, 4'b0101, 1, 0, resp);
    modelWrite(2, 32'hA5A5_A5A5, 4'b0101);
    @(negedge axi_aclk);
    checkOutput("w_first_bresp", vec_t'(resp), vec_t'(RESP_OKAY));
    checkOutput("w_first_reg2", vec_t'(reg_out[2*DW +: DW]), vec_t'(32'h00A5_00A5));
    checkOutput("w_first_wr_stb", vec_t'(wrStbCnt[2] - cntBefore), vec_t'(1));

    $display("[TB] out-of-range write and read");
    snapshot = reg_out;
    applyStimulus(AW'(4 * NR), 32'hFFFF_FFFF, 4'hF, 0, 0, resp);
    checkOutput("oor_bresp", vec_t'(resp), vec_t'(RESP_SLVERR));
    checkOutput("oor_no_change", reg_out, snapshot);
    issueRead(AW'(4 * NR), rdata, rresp);
    checkOutput("oor_rresp", vec_t'(rresp), vec_t'(RESP_SLVERR));
    checkOutput("oor_rdata", vec_t'(rdata), vec_t'(0));

    $display("[TB] read stalled by rready");
    cntBefore = rdStbCnt[4];
    @(negedge axi_aclk);
    axi.arvalid = 1'b1;
    axi.araddr  = 32'h10;
    checkOutput("stall_arready", vec_t'(axi.arready), vec_t'(1'b1));
    @(negedge axi_aclk);
    axi.arvalid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      checkOutput("stall_rvalid", vec_t'({axi.rvalid, axi.arready}), vec_t'(2'b10));
      checkOutput("stall_rdata", vec_t'(axi.rdata), vec_t'(expectedRead(4)));
      @(negedge axi_aclk);
    end
    checkOutput("stall_rdata_c6", vec_t'(axi.rdata), vec_t'(32'h1234_5678));
    axi.rready = 1'b1;
    @(negedge axi_aclk);
    axi.rready = 1'b0;
    checkOutput("stall_release", vec_t'({axi.arready, axi.rvalid}), vec_t'(2'b10));
    checkOutput("stall_rd_stb", vec_t'(rdStbCnt[4] - cntBefore), vec_t'(1));

    $display("[TB] same-cycle read and write of reg3");
    applyStimulus(32'h0C, 32'h1, 4'hF, 0, 0, resp);
    modelWrite(3, 32'h1, 4'hF);
    fork
      applyStimulus(32'h0C, 32'h2, 4'hF, 0, 0, resp);
      issueRead(32'h0C, rdata, rresp);
    join
    checkOutput("rw_same_old", vec_t'(rdata), vec_t'(32'h1));
    modelWrite(3, 32'h2, 4'hF);
    issueRead(32'h0E, rdata, rresp);
    checkOutput("rw_same_reread", vec_t'(rdata), vec_t'(32'h2));

    $display("[TB] read-only register");
    cntBefore = wrStbCnt[1];
    applyStimulus(32'h04, 32'h0, 4'hF, 0, 1, resp);
    checkOutput("ro_bresp", vec_t'(resp), vec_t'(RESP_OKAY));
    checkOutput("ro_no_wr_stb", vec_t'(wrStbCnt[1] - cntBefore), vec_t'(0));
    issueRead(32'h04, rdata, rresp);
    checkOutput("ro_rdata", vec_t'({rresp, rdata}), vec_t'({RESP_OKAY, 32'hDEAD_BEEF}));

`ifdef AXIL_REGFILE_PULSE_EN
    $display("[TB] self-clearing register");
    applyStimulus(32'h00, 32'h5A5A_0001, 4'hF, 0, 0, resp);
    repeat (3) @(negedge axi_aclk);
    checkOutput("pulse_width", vec_t'(pulseHighCycles), vec_t'(1));
    checkOutput("pulse_cleared", vec_t'(reg_out[DW-1:0]), vec_t'(RST_VAL[DW-1:0]));
    issueRead(32'h00, rdata, rresp);
    checkOutput("pulse_read", vec_t'(rdata), vec_t'(RST_VAL[DW-1:0]));
`endif

    $display("[TB] random traffic");
    for (int n = 0; n < 30; n++) begin
      int idx, ridx;
      logic [DW-1:0] data;
      logic [DW/8-1:0] strb;
      idx  = int'($urandom_range(0, NR + 1));
      data = $urandom;
      strb = 4'($urandom_range(0, 15));
      applyStimulus(AW'(idx * 4 + int'($urandom_range(0, 3))), data, strb,
                    int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), resp);
      checkOutput("rand_bresp", vec_t'(resp), vec_t'(expectedResp(idx)));
      modelWrite(idx, data, strb);
      ridx = int'($urandom_range(0, NR + 1));
      issueRead(AW'(ridx * 4 + int'($urandom_range(0, 3))), rdata, rresp);
      checkOutput("rand_rresp", vec_t'(rresp), vec_t'(expectedResp(ridx)));
      checkOutput("rand_rdata", vec_t'(rdata), vec_t'(expectedRead(ridx)));
    end

    @(negedge axi_aclk);
    for (int i = 0; i < NR; i++) begin
      if (!RO_MASK[i] && expectedRead(i) == model[i]) begin
        checkOutput("final_reg_out", vec_t'(reg_out[i*DW +: DW]), vec_t'(model[i]));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
